// File: rtl/ibex_ex_wb_buffer.sv
// Two-entry in-order buffer between the EX result and the register-file write port; LSU writes take the port first.
// Entries retire one cycle after acceptance at the earliest; ex_ready_o drops only when both entries are occupied.
module ibex_ex_wb_buffer #(
  parameter bit          DropX0 = 1'b1,
  parameter int unsigned Depth  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_result_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_we_i,
  output logic        ex_ready_o,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        flush_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        fwd_rs1_hit_o,
  output logic        fwd_rs2_hit_o,
  output logic [31:0] fwd_rs1_data_o,
  output logic [31:0] fwd_rs2_data_o,
  output logic [15:0] stall_cnt_o
);

  if (Depth != 2) begin : gen_depth_check
    $error("ibex_ex_wb_buffer: only Depth == 2 is supported");
  end

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  entry_t      ent_q [2];
  entry_t      ent_d [2];
  entry_t      new_ent;
  logic [15:0] stall_q;
  logic        not_empty;
  logic        enq, deq;
  logic        enq_slot;
  logic        head_drop;
  logic        buf_wr;
  logic        rs1_m1, rs1_m0, rs2_m1, rs2_m0;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (enq) state_d = ONE;
        ONE: begin
          if (enq && !deq)      state_d = FULL;
          else if (!enq && deq) state_d = EMPTY;
        end
        FULL:    if (deq) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output / handshake logic; reset suppresses retirement so pending entries vanish unwritten
  always_comb begin
    ex_ready_o = (state_q != FULL);
    not_empty  = (state_q != EMPTY);
    enq        = ex_valid_i & ex_ready_o & ~flush_i;
    deq        = rst_ni & ~lsu_we_i & not_empty & ~flush_i;
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.rd_addr = ex_rd_addr_i;
    new_ent.rd_we   = ex_rd_we_i;
    new_ent.data    = ex_result_i;

    // Slot 0 is always the head; the new entry lands behind whatever survives this cycle.
    enq_slot = not_empty & ~deq;

    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (flush_i) begin
      ent_d[0].valid = 1'b0;
      ent_d[1].valid = 1'b0;
    end else begin
      if (deq) begin
        ent_d[0]       = ent_q[1];
        ent_d[1].valid = 1'b0;
      end
      if (enq) begin
        ent_d[enq_slot] = new_ent;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (lsu_we_i && not_empty && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;

  always_comb begin
    head_drop  = DropX0 && (ent_q[0].rd_addr == 5'd0);
    buf_wr     = deq & ent_q[0].rd_we & ~head_drop;
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (lsu_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (buf_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ent_q[0].rd_addr;
      rf_wdata_o = ent_q[0].data;
    end
  end

  function automatic logic fwd_match(input entry_t e, input logic [4:0] a);
    return e.valid & e.rd_we & (e.rd_addr == a) & (a != 5'd0);
  endfunction

  // Slot 1 is always younger than slot 0, so it wins on a double match.
  always_comb begin
    rs1_m1         = fwd_match(ent_q[1], rs1_addr_i);
    rs1_m0         = fwd_match(ent_q[0], rs1_addr_i);
    rs2_m1         = fwd_match(ent_q[1], rs2_addr_i);
    rs2_m0         = fwd_match(ent_q[0], rs2_addr_i);
    fwd_rs1_hit_o  = rs1_m1 | rs1_m0;
    fwd_rs2_hit_o  = rs2_m1 | rs2_m0;
    fwd_rs1_data_o = rs1_m1 ? ent_q[1].data : (rs1_m0 ? ent_q[0].data : 32'd0);
    fwd_rs2_data_o = rs2_m1 ? ent_q[1].data : (rs2_m0 ? ent_q[0].data : 32'd0);
  end

endmodule
